// File: rtl/snn_frame_ctrl.sv
// Frame controller: unpacks a UART byte stream into pixels, loads the input RAM,
// runs snn_core and returns the digit over UART. Optional abort watchdog: TIMEOUT_EN.
module snn_frame_ctrl #(
    parameter int NUM_PIXELS     = 784,
    parameter int PIX_W          = 1,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_start,
    input  logic              core_done,
    input  logic [7:0]        core_digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    output logic [7:0]        led,
    output logic              busy,
    output logic              overrun,
    output logic              timeout
);

    localparam int PPB   = 8 / PIX_W;
    localparam int SUB_W = (PPB > 1) ? $clog2(PPB) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [SUB_W-1:0]  LAST_SUB = SUB_W'(PPB - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_PREDICT = 3'd3;
    localparam logic [2:0] S_TX_REQ  = 3'd4;
    localparam logic [2:0] S_TX_WAIT = 3'd5;

    logic [2:0]        state;
    logic [7:0]        hold, pend;
    logic              hold_vld, pend_vld;
    logic [ADDR_W-1:0] pix_cnt;
    logic [SUB_W-1:0]  sub;
    logic              seen_low;

    logic wr, last, cons, rx_blocked;

    assign wr         = (state == S_LOAD) && hold_vld;
    assign last       = wr && (pix_cnt == LAST_PIX);
    assign cons       = wr && ((sub == LAST_SUB) || (pix_cnt == LAST_PIX));
    assign rx_blocked = (state == S_START) || (state == S_PREDICT) ||
                        (state == S_TX_REQ) || (state == S_TX_WAIT);

    assign ram_we     = wr;
    assign ram_addr   = (state == S_IDLE || state == S_LOAD) ? pix_cnt : core_addr;
    assign ram_wdata  = hold[int'(sub)*PIX_W +: PIX_W];
    assign core_start = (state == S_START);
    assign tx_start   = (state == S_TX_REQ) && tx_rdy;
    assign busy       = (state != S_IDLE);

`ifdef TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] idle_cnt;
    logic            to_flag;
    assign timeout = to_flag;
`else
    // the watchdog limit only matters when the abort logic is built in
    logic unused_to_cfg;
    assign unused_to_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            hold     <= '0;
            pend     <= '0;
            hold_vld <= 1'b0;
            pend_vld <= 1'b0;
            pix_cnt  <= '0;
            sub      <= '0;
            seen_low <= 1'b0;
            tx_data  <= '0;
            led      <= '0;
            overrun  <= 1'b0;
`ifdef TIMEOUT_EN
            idle_cnt <= '0;
            to_flag  <= 1'b0;
`endif
        end else begin
            if (rx_rdy && rx_blocked)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
`ifdef TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                    if (rx_rdy) begin
                        hold     <= rx_data;
                        hold_vld <= 1'b1;
                        pend_vld <= 1'b0;
                        pix_cnt  <= '0;
                        sub      <= '0;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (wr) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        sub     <= cons ? '0 : sub + 1'b1;
                    end
                    if (last) begin
                        // leftover high pixels of the final byte and any queued byte are discarded
                        hold_vld <= 1'b0;
                        pend_vld <= 1'b0;
                        pix_cnt  <= '0;
                        state    <= S_START;
                    end else begin
                        if (cons) begin
                            if (pend_vld) begin
                                hold     <= pend;
                                pend_vld <= 1'b0;
                                if (rx_rdy) overrun <= 1'b1;
                            end else if (rx_rdy) begin
                                hold <= rx_data;
                            end else begin
                                hold_vld <= 1'b0;
                            end
                        end else if (rx_rdy) begin
                            if (!hold_vld) begin
                                hold     <= rx_data;
                                hold_vld <= 1'b1;
                            end else if (!pend_vld) begin
                                pend     <= rx_data;
                                pend_vld <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
`ifdef TIMEOUT_EN
                        if (rx_rdy) begin
                            idle_cnt <= '0;
                        end else if (!hold_vld) begin
                            if (idle_cnt == TO_LAST) begin
                                state    <= S_IDLE;
                                hold_vld <= 1'b0;
                                pend_vld <= 1'b0;
                                pix_cnt  <= '0;
                                sub      <= '0;
                                idle_cnt <= '0;
                                to_flag  <= 1'b1;
                            end else begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end

                S_START: state <= S_PREDICT;

                S_PREDICT: begin
                    if (core_done) begin
                        tx_data <= core_digit;
                        led     <= core_digit;
                        state   <= S_TX_REQ;
                    end
                end

                S_TX_REQ: begin
                    if (tx_rdy) begin
                        seen_low <= 1'b0;
                        state    <= S_TX_WAIT;
                    end
                end

                S_TX_WAIT: begin
                    // require a full busy period from the transmitter before releasing
                    if (!tx_rdy) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        seen_low <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Bench for snn_frame_ctrl: per-cycle queue model on a 784x1b instance plus a
// cycle table on a 5x4b instance.
module tb_snn_frame_ctrl;
    localparam int NP = 784, PW = 1, AW = 10, PPB = 8, TO = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          rx_rdy, ram_we, core_start, core_done, tx_start, tx_rdy, busy, overrun, timeout;
    logic [7:0]    rx_data, core_digit, tx_data, led;
    logic [AW-1:0] ram_addr, core_addr;
    logic [PW-1:0] ram_wdata;

    logic          q_rx_rdy, q_ram_we, q_core_start, q_core_done, q_tx_start, q_tx_rdy, q_busy, q_overrun, q_timeout;
    logic [7:0]    q_rx_data, q_core_digit, q_tx_data, q_led;
    logic [2:0]    q_ram_addr, q_core_addr;
    logic [3:0]    q_ram_wdata;

    snn_frame_ctrl #(.NUM_PIXELS(NP), .PIX_W(PW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) u1 (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .core_addr(core_addr), .core_start(core_start),
        .core_done(core_done), .core_digit(core_digit), .tx_start(tx_start), .tx_data(tx_data),
        .tx_rdy(tx_rdy), .led(led), .busy(busy), .overrun(overrun), .timeout(timeout));

    snn_frame_ctrl #(.NUM_PIXELS(5), .PIX_W(4), .ADDR_W(3), .TIMEOUT_CYCLES(TO)) u4 (
        .clk(clk), .rst(rst), .rx_rdy(q_rx_rdy), .rx_data(q_rx_data), .ram_we(q_ram_we),
        .ram_addr(q_ram_addr), .ram_wdata(q_ram_wdata), .core_addr(q_core_addr), .core_start(q_core_start),
        .core_done(q_core_done), .core_digit(q_core_digit), .tx_start(q_tx_start), .tx_data(q_tx_data),
        .tx_rdy(q_tx_rdy), .led(q_led), .busy(q_busy), .overrun(q_overrun), .timeout(q_timeout));

    int total = 0, bad = 0, cyc = 0;

    // reference model: phase 0 idle,1 load,2 start,3 predict,4 tx request,5 tx wait
    int               ph, pos, n, idle, seen;
    byte unsigned     q[$];
    bit               m_ov, m_to;
    logic [7:0]       m_led, m_txd;

    bit               cap_en;
    logic [PW-1:0]    cap[8];
    int               wr_cnt, starts, txp, last_wr_cyc, start_cyc;

    task automatic mreset();
        ph = 0; pos = 0; n = 0; idle = 0; seen = 0; q.delete();
        m_ov = 0; m_to = 0; m_led = 0; m_txd = 0;
    endtask

    task automatic mupdate();
        int  sz;
        bit  lst;
        if (rst) begin
            mreset();
            return;
        end
        case (ph)
            0: if (rx_rdy) begin
                q.delete(); q.push_back(rx_data); pos = 0; n = 0; idle = 0; ph = 1;
            end
            1: begin
                sz  = q.size();
                lst = 0;
                if (sz > 0) begin
                    lst = (n == NP - 1);
                    n++; pos++;
                    if (lst) begin
                        q.delete(); n = 0; ph = 2;
                    end else if (pos == PPB) begin
                        void'(q.pop_front()); pos = 0;
                    end
                end
                if (!lst) begin
                    if (rx_rdy) begin
                        if (sz < 2) q.push_back(rx_data);
                        else m_ov = 1;
                    end
`ifdef TIMEOUT_EN
                    if (rx_rdy) idle = 0;
                    else if (sz == 0) begin
                        if (idle == TO - 1) begin
                            ph = 0; q.delete(); n = 0; idle = 0; m_to = 1;
                        end else idle++;
                    end
`endif
                end
            end
            2: begin
                if (rx_rdy) m_ov = 1;
                ph = 3;
            end
            3: begin
                if (rx_rdy) m_ov = 1;
                if (core_done) begin m_led = core_digit; m_txd = core_digit; ph = 4; end
            end
            4: begin
                if (rx_rdy) m_ov = 1;
                if (tx_rdy) begin seen = 0; ph = 5; end
            end
            default: begin
                if (rx_rdy) m_ov = 1;
                if (!tx_rdy) seen = 1;
                else if (seen != 0) ph = 0;
            end
        endcase
    endtask

    // one clock: check outputs at negedge against the model, then advance the model
    task automatic tick();
        logic [39:0] e, a;
        bit          we_e;
        int          ae, pe;
        core_addr = AW'($urandom);
        @(negedge clk);
        we_e = (ph == 1) && (q.size() > 0);
        ae   = (ph == 0) ? 0 : (ph == 1) ? n : int'(core_addr);
        pe   = we_e ? ((int'(q[0]) >> (pos * PW)) & ((1 << PW) - 1)) : 0;
        e = {we_e, AW'(ae), 8'(pe), ph == 2, (ph == 4) && tx_rdy, m_txd, m_led, ph != 0, m_ov, m_to};
        a = {ram_we, ram_addr, ram_we ? 8'(ram_wdata) : 8'h00, core_start, tx_start, tx_data, led,
             busy, overrun, timeout};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL cyc%0d outputs act=%h exp=%h", cyc, a, e);
        end
        if (ram_we && cap_en) begin
            wr_cnt++;
            if (ram_addr < 8) cap[ram_addr[2:0]] = ram_wdata;
        end
        if (ram_we && ram_addr == AW'(NP - 1)) last_wr_cyc = cyc;
        if (core_start) begin starts++; start_cyc = cyc; end
        if (tx_start) txp++;
        @(posedge clk);
        mupdate();
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        total++; bad++;
        $display("FAIL %s act=timeout exp=progress", nm);
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_rdy = 1; rx_data = d;
        tick();
        rx_rdy = 0;
    endtask

    task automatic load_rest(input int gmin, input int gmax);
        int g, i;
        g = $urandom_range(gmax, gmin);
        i = 0;
        while (ph == 1 && i < 20000) begin
            if (g == 0) begin
                rx_rdy = 1; rx_data = 8'($urandom); g = $urandom_range(gmax, gmin);
            end else begin
                rx_rdy = 0; g--;
            end
            tick();
            i++;
        end
        rx_rdy = 0;
        if (ph == 1) bound_fail("load_bound");
    endtask

    task automatic finish_frame(input int dly, input logic [7:0] dig, input bit stray);
        int i;
        i = 0;
        while (ph == 2 && i < 10) begin tick(); i++; end
        for (int k = 0; k < dly; k++) begin
            if (stray && k == 0) begin rx_rdy = 1; rx_data = 8'($urandom); end
            tick();
            rx_rdy = 0;
        end
        if (ph != 3) bound_fail("predict_entry");
        core_done = 1; core_digit = dig;
        tick();
        core_done = 0; core_digit = 8'($urandom);
        i = 0;
        while (ph != 0 && i < 300) begin
            tx_rdy = 1'($urandom_range(1, 0));
            tick();
            i++;
        end
        tx_rdy = 1;
        if (ph != 0) bound_fail("tx_bound");
    endtask

    typedef struct {
        bit rx; logic [7:0] d; bit done; logic [7:0] dig; bit txr;
        bit we; logic [2:0] addr; logic [3:0] wd; bit cs; bit ts; bit busy; logic [7:0] led;
    } vec_t;
    vec_t tbl[13];

    initial begin
        logic [7:0] led_before;
        logic [31:0] ea, aa;
        rst = 1; rx_rdy = 0; rx_data = 0; core_done = 0; core_digit = 0; tx_rdy = 1; core_addr = 0;
        q_rx_rdy = 0; q_rx_data = 0; q_core_done = 0; q_core_digit = 0; q_tx_rdy = 1; q_core_addr = 3'd6;
        cap_en = 0; wr_cnt = 0; starts = 0; txp = 0; last_wr_cyc = -1; start_cyc = -1;
        mreset();
        @(posedge clk); #1;
        tick(); tick();
        check("reset_q_outs", int'({q_ram_we, q_core_start, q_tx_start, q_busy, q_overrun, q_timeout}), 0);
        check("reset_q_led", int'({q_led, q_tx_data}), 0);
        rst = 0;

        // PIX_W=4, 5 pixels: 0x21,0x43,0xF5 -> 1..5, high nibble of 0xF5 never written
        tbl[0]  = '{1, 8'h21, 0, 8'h00, 1,  0, 3'd0, 4'd0, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 8'h43, 0, 8'h00, 1,  1, 3'd0, 4'd1, 0, 0, 1, 8'h00};
        tbl[2]  = '{0, 8'h00, 0, 8'h00, 1,  1, 3'd1, 4'd2, 0, 0, 1, 8'h00};
        tbl[3]  = '{1, 8'hF5, 0, 8'h00, 1,  1, 3'd2, 4'd3, 0, 0, 1, 8'h00};
        tbl[4]  = '{0, 8'h00, 0, 8'h00, 1,  1, 3'd3, 4'd4, 0, 0, 1, 8'h00};
        tbl[5]  = '{0, 8'h00, 1, 8'h09, 1,  1, 3'd4, 4'd5, 0, 0, 1, 8'h00};
        tbl[6]  = '{0, 8'h00, 0, 8'h00, 1,  0, 3'd0, 4'd0, 1, 0, 1, 8'h00};
        tbl[7]  = '{0, 8'h00, 1, 8'h03, 1,  0, 3'd0, 4'd0, 0, 0, 1, 8'h00};
        tbl[8]  = '{0, 8'h00, 0, 8'h00, 0,  0, 3'd0, 4'd0, 0, 0, 1, 8'h03};
        tbl[9]  = '{0, 8'h00, 0, 8'h00, 1,  0, 3'd0, 4'd0, 0, 1, 1, 8'h03};
        tbl[10] = '{0, 8'h00, 0, 8'h00, 0,  0, 3'd0, 4'd0, 0, 0, 1, 8'h03};
        tbl[11] = '{0, 8'h00, 0, 8'h00, 1,  0, 3'd0, 4'd0, 0, 0, 1, 8'h03};
        tbl[12] = '{0, 8'h00, 0, 8'h00, 1,  0, 3'd0, 4'd0, 0, 0, 0, 8'h03};
        for (int i = 0; i < 13; i++) begin
            q_rx_rdy = tbl[i].rx; q_rx_data = tbl[i].d; q_core_done = tbl[i].done;
            q_core_digit = tbl[i].dig; q_tx_rdy = tbl[i].txr;
            @(negedge clk);
            ea = {tbl[i].we, tbl[i].we ? tbl[i].addr : 3'd0, tbl[i].we ? tbl[i].wd : 4'd0,
                  tbl[i].cs, tbl[i].ts, tbl[i].busy, tbl[i].led, tbl[i].led, q_overrun ? 1'b1 : 1'b0};
            aa = {q_ram_we, q_ram_we ? q_ram_addr : 3'd0, q_ram_we ? q_ram_wdata : 4'd0,
                  q_core_start, q_tx_start, q_busy, q_led, q_tx_data, 1'b0};
            ea[0] = 1'b0;
            total++;
            if (aa !== ea) begin
                bad++;
                $display("FAIL vec%0d q_outputs act=%h exp=%h", i, aa, ea);
            end
            @(posedge clk); #1;
        end
        q_rx_rdy = 0; q_core_done = 0; q_tx_rdy = 1;
        check("q_no_overrun", int'(q_overrun), 0);

        // frame A: 98 evenly spaced bytes, first 0xA5, stray byte during PREDICT
        cap_en = 1; wr_cnt = 0; starts = 0; txp = 0;
        send_byte(8'hA5);
        load_rest(7, 7);
        cap_en = 0;
        check("a_writes", wr_cnt, NP);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a5;
            a5 = 8'hA5;
            check($sformatf("a_pix%0d", i), int'(cap[i]), int'(a5[i]));
        end
        finish_frame(5, 8'd7, 1);
        check("a_starts", starts, 1);
        check("a_start_cyc", start_cyc, last_wr_cyc + 1);
        check("a_tx_pulses", txp, 1);
        check("a_led", int'(led), 7);
        check("a_tx_data", int'(tx_data), 7);
        check("a_busy", int'(busy), 0);
        check("a_overrun", int'(overrun), 1);

        // async reset in the middle of LOAD after 40 bytes
        send_byte(8'h5A);
        for (int k = 0; k < 39; k++) begin
            repeat (7) tick();
            send_byte(8'($urandom));
        end
        led_before = led;
        #2 rst = 1;
        mreset();
        #1;
        check("ar_led_before", int'(led_before), 7);
        check("ar_ram_we", int'(ram_we), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_led", int'(led), 0);
        check("ar_overrun", int'(overrun), 0);
        tick();
        rst = 0;

        // three back-to-back bytes: third dropped; frame restarts at address 0
        send_byte(8'hFF); send_byte(8'h0F); send_byte(8'hAA);
        check("b_overrun", int'(overrun), 1);
        load_rest(7, 7);
        finish_frame(3, 8'd2, 0);

        // random frames with bursty gaps, random core latency and tx handshakes
        for (int f = 0; f < 3; f++) begin
            send_byte(8'($urandom));
            load_rest(0, 12);
            finish_frame($urandom_range(20, 1), 8'($urandom), 1'($urandom_range(1, 0)));
        end

`ifdef TIMEOUT_EN
        starts = 0;
        send_byte(8'h33);
        for (int k = 0; k < 9; k++) begin
            repeat (7) tick();
            send_byte(8'($urandom));
        end
        for (int i = 0; i < 400 && ph == 1; i++) tick();
        check("to_flag", int'(timeout), 1);
        check("to_busy", int'(busy), 0);
        check("to_no_start", starts, 0);
        send_byte(8'h81);
        load_rest(7, 7);
        finish_frame(2, 8'd4, 0);
        check("to_sticky", int'(timeout), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_frame_ctrl.md
Name: snn_frame_ctrl

Overview:
Parametrised frame controller for the SNN digit classifier. It receives a packed pixel frame as a UART byte stream and unpacks each byte into pixel-wide words. It writes the pixels into the input-layer RAM, starts the core, captures the predicted digit, drives the LEDs and sends the digit back over UART TX. It sits between uart_rx/uart_tx, the input RAM and snn_core, and supports configurable pixel depth and frame size.

Parameters:
NUM_PIXELS, 784, pixels per frame (>=1)
PIX_W, 1, bits per pixel; one of 1,2,4,8; PPB = 8/PIX_W pixels per byte, LSB-first
ADDR_W, 10, RAM address width; 2**ADDR_W >= NUM_PIXELS
TIMEOUT_CYCLES, 5000000, idle-cycle limit mid-frame (only with TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_rdy  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte
ram_we  out  1  input RAM write enable
ram_addr  out  ADDR_W  input RAM address (muxed)
ram_wdata  out  PIX_W  pixel to write
core_addr  in  ADDR_W  read address from snn_core
core_start  out  1  one-cycle start pulse to snn_core
core_done  in  1  core result valid
core_digit  in  8  classified digit
tx_start  out  1  one-cycle transmit request
tx_data  out  8  byte to transmit
tx_rdy  in  1  high when transmitter idle
led  out  8  last digit
busy  out  1  state != IDLE
overrun  out  1  sticky: byte dropped
timeout  out  1  sticky: frame aborted (TIMEOUT_EN only, else 0)

Behaviour:
- Reset (async, rst=1): state IDLE. All counters cleared. Hold/pending registers empty. ram_we, core_start, tx_start, busy, overrun and timeout are 0. led=0, tx_data=0.
- ram_addr = pix_cnt in IDLE/LOAD, otherwise core_addr. ram_wdata = hold[sub*PIX_W +: PIX_W].
- Byte buffer: one hold register plus one pending register.
  - rx_rdy while hold is empty: byte goes to hold.
  - rx_rdy while hold is full and pending is empty: byte goes to pending.
  - rx_rdy with both full, or in START/PREDICT/TX_REQ/TX_WAIT: byte dropped, overrun<=1.
  - When hold is consumed and pending is full, pending moves to hold in the same cycle.
- IDLE: rx_rdy -> byte into hold, pix_cnt=0, sub=0, next state LOAD.
- LOAD: each cycle hold is valid, ram_we=1, write pixel at pix_cnt, pix_cnt++, sub++.
  - Hold is consumed when sub==PPB-1 or pix_cnt==NUM_PIXELS-1; sub then resets to 0.
  - A byte received at cycle t gives its first write at t+1; a full byte needs PPB cycles.
  - Write of pix_cnt==NUM_PIXELS-1 -> START. Unused high bits of the final byte are discarded. Hold and pending are cleared.
- START: core_start=1 for one cycle, next PREDICT.
- PREDICT: wait for core_done. On done, latch tx_data<=core_digit and led<=core_digit, next TX_REQ.
- TX_REQ: when tx_rdy=1, tx_start=1 for one cycle, next TX_WAIT.
- TX_WAIT: wait until tx_rdy is seen low, then high, then go to IDLE.
- core_done outside PREDICT is ignored. A rising rst in any state returns to the reset values immediately.

Optional Feature:
TIMEOUT_EN
- Defined: in LOAD, an idle counter counts cycles with hold empty and no rx_rdy, and clears on rx_rdy. When it reaches TIMEOUT_CYCLES-1: state->IDLE, hold/pending cleared, timeout<=1 (sticky until rst), no core_start. Partially written RAM contents are left as they are.
- Undefined: no counter; timeout tied 0; LOAD waits indefinitely.

Test Plan:
- PIX_W=1, NUM_PIXELS=784: send 98 bytes, first 0xA5 -> 784 writes at addr 0..783; addr 0..7 data 1,0,1,0,0,1,0,1; single core_start the cycle after the addr-783 write.
- PIX_W=4, NUM_PIXELS=5: send 0x21,0x43,0xF5 -> writes 1,2,3,4,5 at addr 0..4; nibble 0xF never written; START follows.
- core_done with core_digit=7, tx_rdy=1 -> led=0x07, tx_data=0x07, one tx_start pulse; tx_rdy 1->0->1 -> back to IDLE, busy=0.
- PIX_W=1: three rx_rdy pulses 1 cycle apart -> first two bytes written fully (16 pixels), third dropped, overrun=1; a byte sent during PREDICT also sets overrun and causes no RAM write.
- rst asserted mid-LOAD after 40 bytes -> ram_we=0, busy=0, led=0 asynchronously; next frame starts at addr 0.
- TIMEOUT_EN, TIMEOUT_CYCLES=100: send 10 bytes then stop -> 100 idle cycles later IDLE, timeout=1, no core_start; next byte starts a new frame at addr 0.
